// File: rtl/alu_seq.sv
// Sequential ALU: shifts, zero test, restoring divide, optional multiply.
// Define ALU_SEQ_MUL_EN to enable the shift-add multiplier on opcode 100.
module alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         opcode,
    input  logic [WIDTH-1:0]   portA,
    input  logic [WIDTH-1:0]   portB,
    output logic [2*WIDTH-1:0] result,
    output logic               done,
    output logic               busy,
    output logic               err
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EXEC = 1'b1;

    localparam logic [2:0] OP_SHR = 3'b000;
    localparam logic [2:0] OP_SHL = 3'b001;
    localparam logic [2:0] OP_ISZ = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [2:0] OP_MUL = 3'b100;
`endif

    logic [0:0]         state;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [CW-1:0]      cnt_q;

    logic               acc;
    logic               last;
    logic [WIDTH:0]     tr;
    logic               ge;
    logic [WIDTH-1:0]   rem_n;
    logic [WIDTH-1:0]   quo_n;

    logic               is_shr;
    logic               is_shl;
    logic               is_isz;
    logic               div_z;
    logic               div_go;

    logic               fin;
    logic [2*WIDTH-1:0] res_n;
    logic               err_n;

`ifdef ALU_SEQ_MUL_EN
    logic               is_mul;
    logic [2*WIDTH-1:0] prod_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplr_q;
    logic [2*WIDTH-1:0] prod_n;

    assign is_mul = (op_q == OP_MUL);
    assign prod_n = prod_q + (mplr_q[0] ? mcand_q : '0);
`endif

    assign acc    = (state == IDLE) && start;
    assign last   = (cnt_q == CW'(WIDTH - 1));
    assign is_shr = (op_q == OP_SHR);
    assign is_shl = (op_q == OP_SHL);
    assign is_isz = (op_q == OP_ISZ);
    assign div_z  = (op_q == OP_DIV) && (b_q == '0);
    assign div_go = (op_q == OP_DIV) && (b_q != '0);

    // One restoring-divide step: shift in next dividend bit, try subtract.
    always_comb begin
        tr    = {rem_q, quo_q[WIDTH-1]};
        ge    = (tr >= {1'b0, b_q});
        rem_n = ge ? WIDTH'(tr - {1'b0, b_q}) : tr[WIDTH-1:0];
        quo_n = {quo_q[WIDTH-2:0], ge};
    end

    // Decide whether this EXEC edge completes, and what it writes.
    always_comb begin
        fin   = 1'b1;
        res_n = '0;
        err_n = 1'b1;
        unique case (1'b1)
            is_shr: begin
                res_n = {{WIDTH{1'b0}}, a_q >> b_q};
                err_n = 1'b0;
            end
            is_shl: begin
                res_n = {{WIDTH{1'b0}}, a_q << b_q};
                err_n = 1'b0;
            end
            is_isz: begin
                res_n = {{(2*WIDTH-1){1'b0}}, ~|a_q};
                err_n = 1'b0;
            end
            div_z: begin
                res_n = {a_q, {WIDTH{1'b1}}};
                err_n = 1'b1;
            end
            div_go: begin
                fin   = last;
                res_n = {rem_n, quo_n};
                err_n = 1'b0;
            end
`ifdef ALU_SEQ_MUL_EN
            is_mul: begin
                fin   = last;
                res_n = prod_n;
                err_n = 1'b0;
            end
`endif
            default: begin
                res_n = '0;
                err_n = 1'b1;
            end
        endcase
    end

    // Operand capture on accept, iterative datapath while executing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            rem_q <= '0;
            quo_q <= '0;
`ifdef ALU_SEQ_MUL_EN
            prod_q  <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
`endif
        end else if (acc) begin
            op_q  <= opcode;
            a_q   <= portA;
            b_q   <= portB;
            rem_q <= '0;
            quo_q <= portA;
`ifdef ALU_SEQ_MUL_EN
            prod_q  <= '0;
            mcand_q <= {{WIDTH{1'b0}}, portA};
            mplr_q  <= portB;
`endif
        end else if (state == EXEC) begin
            rem_q <= rem_n;
            quo_q <= quo_n;
`ifdef ALU_SEQ_MUL_EN
            prod_q  <= prod_n;
            mcand_q <= mcand_q << 1;
            mplr_q  <= mplr_q >> 1;
`endif
        end
    end

    // IDLE/EXEC control, step counter and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt_q  <= '0;
            result <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (acc) begin
                state <= EXEC;
                busy  <= 1'b1;
                cnt_q <= '0;
            end else if (state == EXEC) begin
                cnt_q <= cnt_q + CW'(1);
                if (fin) begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    result <= res_n;
                    err    <= err_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=4): transaction model plus directed vectors.
// Honours ALU_SEQ_MUL_EN the same way as the design.
module tb_alu_seq;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [2:0]     opcode = '0;
    logic [W-1:0]   portA = '0;
    logic [W-1:0]   portB = '0;
    logic [2*W-1:0] result;
    logic           done;
    logic           busy;
    logic           err;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .opcode(opcode),
        .portA(portA),
        .portB(portB),
        .result(result),
        .done(done),
        .busy(busy),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference behaviour from plain arithmetic.
    task automatic model_op(input logic [2:0] op, input int a, input int b,
                            output logic [7:0] r, output logic e,
                            output int l);
        int v;
        r = 8'h00;
        e = 1'b1;
        l = 1;
        case (op)
            3'd0: begin
                v = (b >= W) ? 0 : a / (1 << b);
                r = 8'(v);
                e = 1'b0;
            end
            3'd1: begin
                v = (b >= W) ? 0 : (a * (1 << b)) % 16;
                r = 8'(v);
                e = 1'b0;
            end
            3'd2: begin
                r = (a == 0) ? 8'h01 : 8'h00;
                e = 1'b0;
            end
            3'd3: begin
                if (b == 0) begin
                    r = 8'(a * 16 + 15);
                    e = 1'b1;
                end else begin
                    r = 8'((a % b) * 16 + a / b);
                    e = 1'b0;
                    l = W;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            3'd4: begin
                r = 8'(a * b);
                e = 1'b0;
                l = W;
            end
`endif
            default: begin
                r = 8'h00;
                e = 1'b1;
            end
        endcase
    endtask

    logic [7:0] m_result = '0;
    logic       m_err = 1'b0;
    logic       m_done = 1'b0;
    logic       m_busy = 1'b0;
    int         m_left = 0;
    logic [7:0] p_r;
    logic       p_e;

    // Transaction-level model: one accept, L edges, one done pulse.
    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_result = '0;
                m_err = 1'b0;
                m_done = 1'b0;
                m_busy = 1'b0;
                m_left = 0;
            end else begin
                m_done = 1'b0;
                if (!m_busy) begin
                    if (start) begin
                        model_op(opcode, int'(portA), int'(portB),
                                 p_r, p_e, m_left);
                        m_busy = 1'b1;
                    end
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                        m_result = p_r;
                        m_err = p_e;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            chk("cyc_done", 32'(done), 32'(m_done));
            chk("cyc_busy", 32'(busy), 32'(m_busy));
            chk("cyc_result", 32'(result), 32'(m_result));
            chk("cyc_err", 32'(err), 32'(m_err));
        end
    end

    task automatic issue(input logic [2:0] op, input logic [3:0] a,
                         input logic [3:0] b);
        start = 1'b1;
        opcode = op;
        portA = a;
        portB = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        opcode = 3'($urandom_range(0, 7));
        portA = 4'($urandom_range(0, 15));
        portB = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_done(input string name, input int lat0,
                             input logic [7:0] er, input logic ee,
                             input int el);
        int lat = lat0;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_lat"}, 32'(lat), 32'(el));
        chk({name, "_res"}, 32'(result), 32'(er));
        chk({name, "_err"}, 32'(err), 32'(ee));
    endtask

    task automatic run(input string name, input logic [2:0] op,
                       input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] er, input logic ee,
                       input int el);
        @(negedge clk);
        issue(op, a, b);
        wait_done(name, 0, er, ee, el);
    endtask

    initial begin
        int dc;
        #1;
        chk("rst_result", 32'(result), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run("shr", 3'd0, 4'b1011, 4'd1, 8'h05, 1'b0, 1);
        run("shl", 3'd1, 4'b1011, 4'd2, 8'h0C, 1'b0, 1);
        run("shl_big", 3'd1, 4'b1011, 4'd5, 8'h00, 1'b0, 1);
        run("isz0", 3'd2, 4'd0, 4'd0, 8'h01, 1'b0, 1);
        issue(3'd2, 4'd5, 4'd0);
        wait_done("isz_b2b", 0, 8'h00, 1'b0, 1);
        run("div", 3'd3, 4'd13, 4'd3, 8'h14, 1'b0, 4);
        run("div0", 3'd3, 4'd9, 4'd0, 8'h9F, 1'b1, 1);
        run("div_ff", 3'd3, 4'd15, 4'd15, 8'h01, 1'b0, 4);
        run("ill5", 3'd5, 4'd7, 4'd3, 8'h00, 1'b1, 1);
        run("clr", 3'd0, 4'd8, 4'd3, 8'h01, 1'b0, 1);
        run("ill7", 3'd7, 4'd1, 4'd1, 8'h00, 1'b1, 1);
`ifdef ALU_SEQ_MUL_EN
        run("mul", 3'd4, 4'd13, 4'd11, 8'h8F, 1'b0, 4);
        run("mul_ff", 3'd4, 4'd15, 4'd15, 8'hE1, 1'b0, 4);
`else
        run("mul_off", 3'd4, 4'd13, 4'd11, 8'h00, 1'b1, 1);
`endif

        @(negedge clk);
        issue(3'd3, 4'd13, 4'd3);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("abort_result", 32'(result), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_err", 32'(err), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        dc = done_cnt;
        repeat (6) @(negedge clk);
        chk("abort_nodone", 32'(done_cnt), 32'(dc));

        run("post_rst", 3'd3, 4'd13, 4'd3, 8'h14, 1'b0, 4);

        @(negedge clk);
        issue(3'd3, 4'd14, 4'd4);
        start = 1'b1;
        opcode = 3'd0;
        portA = 4'd15;
        portB = 4'd0;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore", 1, 8'h23, 1'b0, 4);
        dc = done_cnt;
        repeat (8) @(negedge clk);
        chk("ignore_nodone", 32'(done_cnt), 32'(dc));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
